// File: rtl/stroke_segmenter.sv
// Splits pen strokes into line segments no longer than STEP per axis and
// hands them to a line-draw engine one at a time over a start/finished handshake.
module stroke_segmenter #(
  parameter int STEP        = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pen_valid,
  output logic       pen_ready,
  input  logic       pen_down,
  input  logic [9:0] pen_x,
  input  logic [8:0] pen_y,
  output logic       seg_start,
  input  logic       seg_finished,
  output logic [9:0] x1,
  output logic [8:0] y1,
  output logic [9:0] x2,
  output logic [8:0] y2,
  output logic       busy,
  output logic       seg_err
);

  // state     | meaning
  // IDLE      | waiting for a pen sample (only state with pen_ready)
  // ISSUE     | one-cycle seg_start pulse, endpoints stable on x1..y2
  // WAIT_LOW  | waiting for the engine to drop seg_finished (timed)
  // WAIT_HIGH | engine drawing, waiting for seg_finished to return
  // ADVANCE   | anchor moves to segment end; chain ends or next segment
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ADVANCE} state_t;

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic signed [10:0] STEP_X = 11'(STEP);
  localparam logic signed [9:0]  STEP_Y = 10'(STEP);

  state_t          state, state_d;
  logic            anchor_valid;
  logic [9:0]      ax, tx, src_x, tgt_x, nx;
  logic [8:0]      ay, ty, src_y, tgt_y, ny;
  logic [CW-1:0]   cnt;
  logic            accept, same_as_anchor, at_target;

  function automatic logic [9:0] step_x(input logic [9:0] a, input logic [9:0] t);
    logic signed [10:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, a});
    if (d > STEP_X)       d = STEP_X;
    else if (d < -STEP_X) d = -STEP_X;
    return a + d[9:0];
  endfunction

  function automatic logic [8:0] step_y(input logic [8:0] a, input logic [8:0] t);
    logic signed [9:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, a});
    if (d > STEP_Y)       d = STEP_Y;
    else if (d < -STEP_Y) d = -STEP_Y;
    return a + d[8:0];
  endfunction

  // In IDLE the first sub-endpoint comes straight from the incoming sample;
  // later ones walk from the previous segment end toward the stored target.
  assign src_x = (state == IDLE) ? ax : x2;
  assign src_y = (state == IDLE) ? ay : y2;
  assign tgt_x = (state == IDLE) ? pen_x : tx;
  assign tgt_y = (state == IDLE) ? pen_y : ty;
  assign nx    = step_x(src_x, tgt_x);
  assign ny    = step_y(src_y, tgt_y);

  assign accept         = pen_valid && pen_ready;
  assign same_as_anchor = (pen_x == ax) && (pen_y == ay);
  assign at_target      = (x2 == tx) && (y2 == ty);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    pen_ready = 1'b0;
    seg_start = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        pen_ready = 1'b1;
        busy      = 1'b0;
        if (accept && pen_down && anchor_valid && !same_as_anchor) state_d = ISSUE;
      end
      ISSUE: begin
        seg_start = 1'b1;
        state_d   = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!seg_finished)         state_d = WAIT_HIGH;
        else if (cnt == CNT_LAST)  state_d = ADVANCE;
      end
      WAIT_HIGH: begin
        if (seg_finished) state_d = ADVANCE;
      end
      ADVANCE: state_d = at_target ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anchor_valid <= 1'b0;
      ax      <= '0;
      ay      <= '0;
      tx      <= '0;
      ty      <= '0;
      x1      <= '0;
      y1      <= '0;
      x2      <= '0;
      y2      <= '0;
      cnt     <= '0;
      seg_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!pen_down) begin
              anchor_valid <= 1'b0;
            end else if (!anchor_valid) begin
              ax           <= pen_x;
              ay           <= pen_y;
              anchor_valid <= 1'b1;
            end else begin
              tx <= pen_x;
              ty <= pen_y;
              if (!same_as_anchor) begin
                x1 <= ax;
                y1 <= ay;
                x2 <= nx;
                y2 <= ny;
              end
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT_LOW: begin
          if (seg_finished) begin
            if (cnt == CNT_LAST) seg_err <= 1'b1;
            else                 cnt <= cnt + CW'(1);
          end
        end
        ADVANCE: begin
          ax <= x2;
          ay <= y2;
          if (!at_target) begin
            x1 <= x2;
            y1 <= y2;
            x2 <= nx;
            y2 <= ny;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stroke_segmenter.md
STROKE_SEGMENTER -- requirements
Module: stroke_segmenter

Interface
REQ-001 Parameter STEP, default 16, max per-axis advance of one issued segment; legal range 1..19.
REQ-002 Parameter ACK_TIMEOUT, default 4, cycles allowed for seg_finished to fall after a start pulse.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pen_valid  input  1  pen sample present.
REQ-006 pen_ready  output  1  sample accepted when pen_valid && pen_ready at a clock edge.
REQ-007 pen_down  input  1  1 = drawing, 0 = pen lifted.
REQ-008 pen_x  input  10  sample x, 0..639; pen_y  input  9  sample y, 0..479.
REQ-009 seg_start  output  1  one-cycle start pulse to the line-draw engine.
REQ-010 seg_finished  input  1  engine status: 1 = idle/done, 0 = drawing.
REQ-011 x1 output 10, y1 output 9, x2 output 10, y2 output 9: segment endpoints to the engine.
REQ-012 busy  output  1  state != IDLE; seg_err  output  1  sticky rejected-segment flag.

Function
REQ-013 States SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ADVANCE.
REQ-014 pen_ready SHALL be 1 only in IDLE; samples are never dropped or buffered beyond the handshake.
REQ-015 Accepted sample with pen_down=0 SHALL clear anchor_valid; state stays IDLE.
REQ-016 Accepted sample with pen_down=1 and anchor_valid=0 SHALL load anchor (ax,ay) := (pen_x,pen_y), set anchor_valid; no segment.
REQ-017 Accepted sample with pen_down=1, anchor_valid=1 SHALL load target (tx,ty); if target equals anchor stay IDLE, else compute sub-endpoint and go to ISSUE next cycle.
REQ-018 Sub-endpoint: nx = ax + clamp(tx-ax, -STEP, +STEP), ny = ay + clamp(ty-ay, -STEP, +STEP); each axis independent; deltas in signed 11-bit (x) / 10-bit (y); result always lies between anchor and target, no wrap.
REQ-019 x1=ax, y1=ay, x2=nx, y2=ny SHALL be registered and held stable from entry to ISSUE until leaving ADVANCE.
REQ-020 ISSUE: seg_start=1 for exactly one cycle, then WAIT_LOW with timeout counter cleared; seg_start is 0 in every other state.
REQ-021 WAIT_LOW: seg_finished=0 -> WAIT_HIGH; else counter increments; after ACK_TIMEOUT cycles with seg_finished=1 -> set seg_err, go to ADVANCE (segment treated as rejected).
REQ-022 WAIT_HIGH: seg_finished=1 -> ADVANCE; no timeout.
REQ-023 ADVANCE (one cycle): anchor := (nx,ny); if (nx,ny)==target -> IDLE, else compute next sub-endpoint -> ISSUE.
REQ-024 Consecutive start pulses SHALL be separated by at least 2 low cycles (guaranteed by WAIT/ADVANCE path).
REQ-025 Segments of a chain SHALL share endpoints: x1,y1 of segment k+1 equal x2,y2 of segment k.

Reset
REQ-026 reset SHALL force IDLE, seg_start=0, busy=0, seg_err=0, anchor_valid=0, x1=y1=x2=y2=0, counter=0; pen_ready=1 the cycle after reset deasserts.
REQ-027 reset mid-chain (any state) SHALL abort with no further seg_start pulse; the next sample restarts as a fresh anchor.

Verification (engine model: seg_finished falls 1 cycle after seg_start, rises 3 cycles later)
REQ-028 Reset then idle -> all outputs 0 except pen_ready=1; no seg_start.
REQ-029 pen_down samples (100,50) then (110,60) -> exactly one pulse, endpoints (100,50)-(110,60), back to IDLE, pen_ready=1.
REQ-030 (0,0) then (40,10) -> three pulses: (0,0)-(16,10), (16,10)-(32,10), (32,10)-(40,10); busy=1 throughout chain.
REQ-031 (639,479) then (600,479) -> (639,479)-(623,479), (623,479)-(607,479), (607,479)-(600,479).
REQ-032 Engine model holds seg_finished=1 -> seg_err=1 ACK_TIMEOUT cycles after pulse, chain continues, seg_err stays 1 until reset.
REQ-033 Pen-up sample between (10,10) and (20,20) -> no segment; reset asserted in WAIT_HIGH -> no further pulse, next sample only anchors.
